// File: rtl/tdm_demux16.sv
// Receive side of the TDM link: rebuilds LANES serial slots into a parallel word
// and hands it to the consumer through a single valid/ready holding register.

module tdm_demux16_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wr,
  input  logic i_clr,
  input  logic i_din,
  input  logic i_load,
  output logic o_fill,
  output logic o_out
);
  logic r_fill, r_out;

  // A write beats the abandon-clear so lane 0 picks up the early-sof bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= 1'b0;
      r_out  <= 1'b0;
    end else begin
      if (i_wr)       r_fill <= i_din;
      else if (i_clr) r_fill <= 1'b0;
      if (i_load)     r_out  <= r_fill;
    end
  end

  assign o_fill = r_fill;
  assign o_out  = r_out;
endmodule

module tdm_demux16 #(
  parameter int LANES = 16,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [LANES-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SELW-1:0]  slot,
  output logic             busy,
  output logic             sync_err,
  output logic             overrun,
  input  logic             clr_ovr
);
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic [SELW-1:0] LAST = SELW'(LANES - 1);

  state_t            r_state;
  logic [SELW-1:0]   r_slot;
  logic              r_done, r_out_valid, r_sync_err, r_overrun;
  logic              w_accept, w_abandon, w_done, w_load;
  logic [SELW-1:0]   w_idx;
  logic [LANES-1:0]  w_wr, w_fill, w_out;

  assign w_accept  = din_valid & (sof | (r_state == FILL));
  assign w_idx     = sof ? '0 : r_slot;
  assign w_abandon = din_valid & sof & (r_state == FILL);
  assign w_done    = din_valid & ~sof & (r_state == FILL) & (r_slot == LAST);
  // Completed word moves out one cycle later, when the holder is free or draining.
  assign w_load    = r_done & (~r_out_valid | out_ready);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_wr[i] = w_accept & (w_idx == SELW'(i));
    tdm_demux16_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_wr   (w_wr[i]),
      .i_clr  (w_abandon),
      .i_din  (din),
      .i_load (w_load),
      .o_fill (w_fill[i]),
      .o_out  (w_out[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_slot      <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync_err <= w_abandon;
      r_done     <= w_done;
      if (w_accept) begin
        r_slot  <= w_idx + 1'b1;
        r_state <= w_done ? IDLE : FILL;
      end
      if (w_load)         r_out_valid <= 1'b1;
      else if (out_ready) r_out_valid <= 1'b0;
      if (r_done & r_out_valid & ~out_ready) r_overrun <= 1'b1;
      else if (clr_ovr)                      r_overrun <= 1'b0;
    end
  end

  assign out       = w_out;
  assign out_valid = r_out_valid;
  assign slot      = r_slot;
  assign busy      = (r_state == FILL);
  assign sync_err  = r_sync_err;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16 with a frame-level reference model and per-cycle compare.

module tb_tdm_demux16;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        din = 1'b0, din_valid = 1'b0, sof = 1'b0, out_ready = 1'b0, clr_ovr = 1'b0;
  logic [15:0] out;
  logic        out_valid, busy, sync_err, overrun;
  logic [3:0]  slot;

  int checks = 0, errors = 0;
  bit run = 0;

  always #5 clk = ~clk;

  tdm_demux16 #(.LANES(16), .SELW(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .sof(sof),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .slot(slot),
    .busy(busy), .sync_err(sync_err), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  // Frame-level model: m_pos = next slot of the frame being built, -1 when no frame open.
  int          m_pos = -1;
  logic [15:0] m_word = '0, m_out = '0, m_pend_word = '0;
  bit          m_pend = 0, m_np = 0, m_ov = 0, m_ovr = 0, m_se = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = -1; m_word = '0; m_out = '0; m_pend = 0;
      m_ov = 0; m_ovr = 0; m_se = 0;
    end else begin
      m_np = 0;
      if (clr_ovr) m_ovr = 0;
      if (m_pend) begin
        if (!m_ov || out_ready) begin m_out = m_pend_word; m_ov = 1; end
        else m_ovr = 1;
      end else if (m_ov && out_ready) m_ov = 0;
      m_se = 0;
      if (din_valid) begin
        if (sof) begin
          m_se = (m_pos >= 0);
          m_word = '0;
          m_word[0] = din;
          m_pos = 1;
        end else if (m_pos >= 0) begin
          m_word[m_pos] = din;
          m_pos++;
          if (m_pos == 16) begin m_np = 1; m_pend_word = m_word; m_pos = -1; end
        end
      end
      m_pend = m_np;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      logic [3:0] es;
      es = (m_pos < 0) ? 4'd0 : 4'(m_pos);
      checks++;
      if (out !== m_out || out_valid !== m_ov || slot !== es || busy !== (m_pos >= 0) ||
          sync_err !== m_se || overrun !== m_ovr) begin
        errors++;
        $display("FAIL cycle t=%0t got out=%h v=%b slot=%0d busy=%b se=%b ovr=%b exp out=%h v=%b slot=%0d busy=%b se=%b ovr=%b",
                 $time, out, out_valid, slot, busy, sync_err, overrun,
                 m_out, m_ov, es, (m_pos >= 0), m_se, m_ovr);
      end
    end
  end

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask

  task automatic cyc(bit v, bit s, bit d);
    @(posedge clk); #2;
    din_valid = v; sof = s; din = d;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0);
  endtask

  task automatic send_frame(logic [15:0] w, int gap_a, int gap_b);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_a || i == gap_b) idle(3);
      cyc(1, i == 0, w[i]);
    end
  endtask

  initial begin
    #12;
    chk("reset out", out, 0);
    chk("reset flags", {out_valid, busy, sync_err, overrun, slot}, 0);
    @(posedge clk); #2 rst_n = 1'b1; run = 1;

    // Basic back-to-back frame
    out_ready = 1'b1;
    send_frame(16'hA5C3, -1, -1);
    cyc(0, 0, 0);
    @(posedge clk); #1;
    chk("basic out", out, 16'hA5C3);
    chk("basic model", m_out, 16'hA5C3);
    chk("basic v/slot/busy", {out_valid, slot, busy}, {1'b1, 4'd0, 1'b0});
    idle(3);

    // Gaps inside the frame
    send_frame(16'hA5C3, 5, 12);
    idle(2);
    chk("gap out", out, 16'hA5C3);
    idle(2);

    // Early sof abandons the partial frame
    cyc(1, 1, 1);
    repeat (6) cyc(1, 0, 1);
    cyc(1, 1, 1);
    cyc(1, 0, 0); #1;
    chk("sync_err pulse", sync_err, 1);
    repeat (14) cyc(1, 0, 0);
    cyc(0, 0, 0);
    @(posedge clk); #1;
    chk("sync out", out, 16'h0001);
    chk("sync model", m_out, 16'h0001);
    idle(3);

    // Backpressure and overrun
    out_ready = 1'b0;
    send_frame(16'h1234, -1, -1);
    send_frame(16'hFFFF, -1, -1);
    idle(3); #1;
    chk("ovr out held", out, 16'h1234);
    chk("ovr flags", {out_valid, overrun}, 2'b11);
    cyc(0, 0, 0); clr_ovr = 1'b1;
    @(posedge clk); #2 clr_ovr = 1'b0; #1;
    chk("ovr cleared", overrun, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain v", out_valid, 0);
    idle(2);

    // Consume and load on the same edge
    out_ready = 1'b0;
    send_frame(16'h00FF, -1, -1);
    idle(3); #1;
    chk("held 00FF", out, 16'h00FF);
    send_frame(16'hFF00, -1, -1);
    cyc(0, 0, 0); out_ready = 1'b1;
    @(posedge clk); #2 out_ready = 1'b0; #1;
    chk("swap out", out, 16'hFF00);
    chk("swap flags", {out_valid, overrun}, 2'b10);
    idle(2);

    // Async reset mid-frame with a frame held in out
    for (int i = 0; i < 10; i++) cyc(1, i == 0, i[0]);
    #1 rst_n = 1'b0; #1;
    chk("arst out", out, 0);
    chk("arst flags", {out_valid, busy, sync_err, overrun, slot}, 0);
    idle(2);
    rst_n = 1'b1;
    repeat (3) cyc(1, 0, 1);
    cyc(0, 0, 0); #1;
    chk("no-sof ignored", {busy, slot, out_valid}, 0);
    out_ready = 1'b1;
    send_frame(16'h8001, -1, -1);
    cyc(0, 0, 0);
    @(posedge clk); #1;
    chk("post-reset out", out, 16'h8001);
    chk("post-reset model", m_out, 16'h8001);
    idle(3);

    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
